// File: rtl/morse_encoder_tx.sv
// morse_encoder_tx
//   Serialises ASCII characters into an ITU Morse key waveform.
//   One Morse time unit lasts DOT_CYCLES clock cycles:
//     dot = 1 unit mark, dash = 3 units mark, gap between elements = 1 unit,
//     gap after a character = 3 units, space character = 4 further units.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   char_valid : char_data holds a character to send
//   char_data  : ASCII character (A-Z, a-z, 0-9, space supported)
//   char_ready : block accepts a character this cycle (IDLE only)
//   key_out    : registered Morse key, 1 = tone
//   busy       : inverse of char_ready
//   err_pulse  : one-cycle pulse after an unsupported character is accepted
module morse_encoder_tx #(
  parameter int DOT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       err_pulse
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] MARK       = 3'd1;
  localparam logic [2:0] ELEM_GAP   = 3'd2;
  localparam logic [2:0] LETTER_GAP = 3'd3;
  localparam logic [2:0] WORD_GAP   = 3'd4;

  localparam logic [23:0] DOT_LAST = 24'(DOT_CYCLES - 1);

  logic [2:0]  state_reg, state_next;
  logic [23:0] cyc_reg, cyc_next;
  logic [2:0]  unit_reg, unit_next;
  logic [2:0]  elem_reg, elem_next;
  logic [4:0]  pat_reg, pat_next;
  logic [2:0]  len_reg, len_next;
  logic        err_next;

  // Lookup results for the character currently presented
  logic [7:0] up_char;
  logic [2:0] lut_len;
  logic [4:0] lut_pat;
  logic       lut_ok;
  logic       is_space;

  // Timing helpers
  logic [4:0] pat_shift;
  logic       cur_dash;
  logic [2:0] units_needed;
  logic       unit_done;
  logic       seg_done;

  // Patterns are left-aligned: bit 4 is the first element, 1 = dash.
  always_comb begin
    up_char  = (char_data >= 8'h61 && char_data <= 8'h7a) ? (char_data - 8'h20) : char_data;
    is_space = (char_data == 8'h20);
    lut_ok   = 1'b1;
    lut_len  = 3'd0;
    lut_pat  = 5'b00000;
    case (up_char)
      "A": begin lut_len = 3'd2; lut_pat = 5'b01000; end
      "B": begin lut_len = 3'd4; lut_pat = 5'b10000; end
      "C": begin lut_len = 3'd4; lut_pat = 5'b10100; end
      "D": begin lut_len = 3'd3; lut_pat = 5'b10000; end
      "E": begin lut_len = 3'd1; lut_pat = 5'b00000; end
      "F": begin lut_len = 3'd4; lut_pat = 5'b00100; end
      "G": begin lut_len = 3'd3; lut_pat = 5'b11000; end
      "H": begin lut_len = 3'd4; lut_pat = 5'b00000; end
      "I": begin lut_len = 3'd2; lut_pat = 5'b00000; end
      "J": begin lut_len = 3'd4; lut_pat = 5'b01110; end
      "K": begin lut_len = 3'd3; lut_pat = 5'b10100; end
      "L": begin lut_len = 3'd4; lut_pat = 5'b01000; end
      "M": begin lut_len = 3'd2; lut_pat = 5'b11000; end
      "N": begin lut_len = 3'd2; lut_pat = 5'b10000; end
      "O": begin lut_len = 3'd3; lut_pat = 5'b11100; end
      "P": begin lut_len = 3'd4; lut_pat = 5'b01100; end
      "Q": begin lut_len = 3'd4; lut_pat = 5'b11010; end
      "R": begin lut_len = 3'd3; lut_pat = 5'b01000; end
      "S": begin lut_len = 3'd3; lut_pat = 5'b00000; end
      "T": begin lut_len = 3'd1; lut_pat = 5'b10000; end
      "U": begin lut_len = 3'd3; lut_pat = 5'b00100; end
      "V": begin lut_len = 3'd4; lut_pat = 5'b00010; end
      "W": begin lut_len = 3'd3; lut_pat = 5'b01100; end
      "X": begin lut_len = 3'd4; lut_pat = 5'b10010; end
      "Y": begin lut_len = 3'd4; lut_pat = 5'b10110; end
      "Z": begin lut_len = 3'd4; lut_pat = 5'b11000; end
      "0": begin lut_len = 3'd5; lut_pat = 5'b11111; end
      "1": begin lut_len = 3'd5; lut_pat = 5'b01111; end
      "2": begin lut_len = 3'd5; lut_pat = 5'b00111; end
      "3": begin lut_len = 3'd5; lut_pat = 5'b00011; end
      "4": begin lut_len = 3'd5; lut_pat = 5'b00001; end
      "5": begin lut_len = 3'd5; lut_pat = 5'b00000; end
      "6": begin lut_len = 3'd5; lut_pat = 5'b10000; end
      "7": begin lut_len = 3'd5; lut_pat = 5'b11000; end
      "8": begin lut_len = 3'd5; lut_pat = 5'b11100; end
      "9": begin lut_len = 3'd5; lut_pat = 5'b11110; end
      default: lut_ok = 1'b0;
    endcase
  end

  always_comb begin
    pat_shift = pat_reg << elem_reg;
    cur_dash  = pat_shift[4];
    case (state_reg)
      MARK:       units_needed = cur_dash ? 3'd3 : 3'd1;
      ELEM_GAP:   units_needed = 3'd1;
      LETTER_GAP: units_needed = 3'd3;
      WORD_GAP:   units_needed = 3'd4;
      default:    units_needed = 3'd1;
    endcase
    unit_done = (cyc_reg == DOT_LAST);
    seg_done  = unit_done && (unit_reg == units_needed - 3'd1);
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = unit_done ? 24'd0 : cyc_reg + 24'd1;
    unit_next  = unit_done ? unit_reg + 3'd1 : unit_reg;
    elem_next  = elem_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        elem_next = 3'd0;
        if (char_valid) begin
          if (is_space) begin
            state_next = WORD_GAP;
          end else if (lut_ok) begin
            state_next = MARK;
            pat_next   = lut_pat;
            len_next   = lut_len;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      MARK: begin
        if (seg_done) begin
          if (elem_reg == len_reg - 3'd1) begin
            state_next = LETTER_GAP;
          end else begin
            state_next = ELEM_GAP;
            elem_next  = elem_reg + 3'd1;
          end
        end
      end
      ELEM_GAP: begin
        if (seg_done) state_next = MARK;
      end
      LETTER_GAP, WORD_GAP: begin
        if (seg_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Timing restarts from zero whenever a new state is entered; IDLE
    // keeps the counters parked at zero as well.
    if (state_next != state_reg || state_reg == IDLE) begin
      cyc_next  = 24'd0;
      unit_next = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cyc_reg   <= 24'd0;
      unit_reg  <= 3'd0;
      elem_reg  <= 3'd0;
      pat_reg   <= 5'd0;
      len_reg   <= 3'd0;
      key_out   <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      unit_reg  <= unit_next;
      elem_reg  <= elem_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      // Registered from the next state so the key tracks MARK exactly
      // and never glitches.
      key_out   <= (state_next == MARK);
      err_pulse <= err_next;
    end
  end

  assign char_ready = (state_reg == IDLE);
  assign busy       = ~char_ready;

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed bench for morse_encoder_tx with DOT_CYCLES = 4.
module tb_morse_encoder_tx;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       err_pulse;

  int checks = 0;
  int errors = 0;

  morse_encoder_tx #(.DOT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one character, let the next rising edge accept it, then
  // scramble char_data so the latched pattern is what gets sent.
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'h23;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (key_out !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: key=%b ready=%b busy=%b err=%b, expected 0 1 0 0",
               key_out, char_ready, busy, err_pulse);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: key=%b ready=%b busy=%b", key_out, char_ready, busy);
  endtask

  task automatic test_e();
    logic exp_key;
    send("E");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_key = (i < 4);
      checks++;
      if (key_out !== exp_key || busy !== 1'b1 || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL e_wave cycle %0d: key=%b busy=%b err=%b, expected key=%b busy=1 err=0",
                 i, key_out, busy, err_pulse, exp_key);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1 || key_out !== 1'b0) begin
      errors++;
      $display("FAIL e_done: ready=%b key=%b, expected ready=1 key=0", char_ready, key_out);
    end
    $display("char 'E': 16 cycles checked");
  endtask

  task automatic test_a();
    logic exp_key;
    send("A");
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp_key = (i < 4) || (i >= 8 && i < 20);
      checks++;
      if (key_out !== exp_key || busy !== 1'b1) begin
        errors++;
        $display("FAIL a_wave cycle %0d: key=%b busy=%b, expected key=%b busy=1",
                 i, key_out, busy, exp_key);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_done: ready=%b, expected 1", char_ready);
    end
    $display("char 'A': 32 cycles checked");
  endtask

  task automatic test_back_to_back();
    logic exp_key;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = "a";
    @(posedge clk);
    #1;
    char_data = "0";   // held valid: must wait for the next IDLE cycle
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp_key = (i < 4) || (i >= 8 && i < 20);
      checks++;
      if (key_out !== exp_key || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_a_wave cycle %0d: key=%b busy=%b, expected key=%b busy=1",
                 i, key_out, busy, exp_key);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1 || key_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: ready=%b key=%b, expected ready=1 key=0", char_ready, key_out);
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'h23;
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      exp_key = (i < 76) && ((i % 16) < 12);
      checks++;
      if (key_out !== exp_key || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_0_wave cycle %0d: key=%b busy=%b, expected key=%b busy=1",
                 i, key_out, busy, exp_key);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: ready=%b, expected 1", char_ready);
    end
    $display("chars 'a','0' back to back: 121 cycles checked");
  endtask

  task automatic test_space();
    send(8'h20);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (key_out !== 1'b0 || busy !== 1'b1 || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL space_wave cycle %0d: key=%b busy=%b err=%b, expected key=0 busy=1 err=0",
                 i, key_out, busy, err_pulse);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL space_done: ready=%b, expected 1", char_ready);
    end
    $display("char ' ': 16 cycles checked");
  endtask

  task automatic test_unsupported();
    send("#");
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b1 || key_out !== 1'b0 || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL unsup_pulse: err=%b key=%b ready=%b, expected err=1 key=0 ready=1",
               err_pulse, key_out, char_ready);
    end
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || key_out !== 1'b0 || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL unsup_after: err=%b key=%b ready=%b, expected err=0 key=0 ready=1",
               err_pulse, key_out, char_ready);
    end
    $display("char '#': error pulse checked");
  endtask

  task automatic test_reset_mid_char();
    logic exp_key;
    send("T");
    @(negedge clk);
    @(negedge clk);   // second cycle of the dash
    checks++;
    if (key_out !== 1'b1) begin
      errors++;
      $display("FAIL t_dash_on: key=%b, expected 1", key_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (key_out !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: key=%b ready=%b busy=%b, expected key=0 ready=1 busy=0",
               key_out, char_ready, busy);
    end
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    char_valid = 1'b1;
    char_data  = "E";
    @(posedge clk);   // first edge after release must accept
    #1;
    char_valid = 1'b0;
    char_data  = 8'h23;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_key = (i < 4);
      checks++;
      if (key_out !== exp_key || busy !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_e cycle %0d: key=%b busy=%b, expected key=%b busy=1",
                 i, key_out, busy, exp_key);
      end
    end
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_done: ready=%b, expected 1", char_ready);
    end
    $display("reset during 'T' then 'E': checked");
  endtask

  initial begin
    test_reset();
    test_e();
    test_a();
    test_back_to_back();
    test_space();
    test_unsupported();
    test_reset_mid_char();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
